// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator sequencer.
// Optional feature macro: CALC_TIMEOUT_EN (ALU watchdog).
package calc_pkg;

    localparam int WORD_W   = 32;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        EDIT   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DIV   = 2'b00,
        PLUS  = 2'b01,
        MINUS = 2'b10,
        MUL   = 2'b11
    } op_e;

endpackage

// File: rtl/calc_sequencer_if.sv
// User/ALU/LCD signal bundle of the calculator sequencer.
// master: the environment (keypad, buttons, ALU, LCD). slave: calc_sequencer.
interface calc_sequencer_if;
    import calc_pkg::*;

    logic                key_valid;
    logic [NIBBLE_W-1:0] key_code;
    logic                sel_tgl;
    logic                op_next;
    logic                clr;
    logic                go;
    logic                alu_done;
    logic [WORD_W-1:0]   alu_result;
    logic                lcd_ack;
    logic [WORD_W-1:0]   a;
    logic [WORD_W-1:0]   b;
    logic [WORD_W-1:0]   c;
    logic [1:0]          operation;
    logic                sel;
    logic                alu_start;
    logic                busy;
    logic                err;
    logic                lcd_req;

    modport master (
        output key_valid, key_code, sel_tgl, op_next, clr, go,
               alu_done, alu_result, lcd_ack,
        input  a, b, c, operation, sel, alu_start, busy, err, lcd_req
    );

    modport slave (
        input  key_valid, key_code, sel_tgl, op_next, clr, go,
               alu_done, alu_result, lcd_ack,
        output a, b, c, operation, sel, alu_start, busy, err, lcd_req
    );

endinterface

// File: rtl/calc_watchdog.sv
// ALU watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT-th one. Instantiated only when CALC_TIMEOUT_EN is defined.
module calc_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // count_reg holds the number of enabled cycles already elapsed, so the
    // TIMEOUT-th enabled cycle is the one that sees TIMEOUT-1.
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] count_reg;

    assign expired = enable && (count_reg == CNT_W'(TIMEOUT - 1));

    // Clear on launch, then count enabled cycles, saturating at expiry.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: builds operands A/B from keypad digits, selects the
// operation, runs one ALU start/done transaction per GO and keeps a
// coalescing LCD refresh request.
// Optional feature macro: CALC_TIMEOUT_EN (ALU watchdog and sticky ERR).
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int                TIMEOUT = 1024,
    parameter logic [WORD_W-1:0] A_INIT  = 32'h0000_0000,
    parameter logic [WORD_W-1:0] B_INIT  = 32'h0000_0000
) (
    input logic             CLK,
    input logic             RESET,
    calc_sequencer_if.slave bus
);

    localparam logic [1:0] S_EDIT   = EDIT;
    localparam logic [1:0] S_LAUNCH = LAUNCH;
    localparam logic [1:0] S_WAIT   = WAIT;

    logic [1:0]        state_reg, state_next;
    logic [WORD_W-1:0] c_reg, c_next;
    logic [1:0]        oper_reg, oper_next;
    logic              sel_reg, sel_next;
    logic              err_reg, err_next;
    logic              lcd_req_reg, lcd_req_next;

    logic in_edit, in_launch, in_wait;
    logic do_clr, do_key, do_sel, do_op;
    logic wd_expired;
    logic changed;

    assign in_edit   = (state_reg == S_EDIT);
    assign in_launch = (state_reg == S_LAUNCH);
    assign in_wait   = (state_reg == S_WAIT);

    // Edit inputs only act in EDIT; only the highest-priority one is used.
    assign do_clr = in_edit && bus.clr;
    assign do_key = in_edit && !bus.clr && bus.key_valid;
    assign do_sel = in_edit && !bus.clr && !bus.key_valid && bus.sel_tgl;
    assign do_op  = in_edit && !bus.clr && !bus.key_valid && !bus.sel_tgl && bus.op_next;

    // Operand registers: index 0 is A, index 1 is B; only the selected one edits.
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
        localparam logic [WORD_W-1:0] INIT = (gi == 0) ? A_INIT : B_INIT;

        logic [WORD_W-1:0] opnd_reg, opnd_next;
        logic              hit;
        logic              opnd_chg;

        assign hit      = (int'(sel_reg) == gi);
        assign opnd_chg = (opnd_next != opnd_reg);

        // Clear or shift in a new low nibble, dropping the oldest one.
        always_comb begin
            opnd_next = opnd_reg;
            if (hit && do_clr) begin
                opnd_next = '0;
            end else if (hit && do_key) begin
                opnd_next = {opnd_reg[WORD_W-NIBBLE_W-1:0], bus.key_code};
            end
        end

        // Operand storage.
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                opnd_reg <= INIT;
            end else begin
                opnd_reg <= opnd_next;
            end
        end
    end

`ifdef CALC_TIMEOUT_EN
    calc_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (in_launch),
        .enable  (in_wait),
        .expired (wd_expired)
    );
`else
    // No watchdog: WAIT only ends on alu_done and ERR never sets.
    assign wd_expired = 1'b0 && (TIMEOUT < 2);
`endif

    // Sequencing, result capture, selection, operation and error flag.
    always_comb begin
        state_next = state_reg;
        c_next     = c_reg;
        oper_next  = oper_reg;
        sel_next   = sel_reg;
        err_next   = err_reg;
        case (state_reg)
            S_EDIT: begin
                if (do_sel) sel_next = ~sel_reg;
                if (do_op) oper_next = oper_reg + 2'd1;
                if (do_clr || bus.go) err_next = 1'b0;
                if (bus.go) state_next = S_LAUNCH;
            end
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT: begin
                // A done arriving with the expiry cycle takes precedence.
                if (bus.alu_done) begin
                    c_next     = bus.alu_result;
                    state_next = S_EDIT;
                end else if (wd_expired) begin
                    err_next   = 1'b1;
                    state_next = S_EDIT;
                end
            end
            default: state_next = S_EDIT;
        endcase
    end

    // Any visible change raises the refresh; an ack only clears a quiet cycle.
    always_comb begin
        changed = g_opnd[0].opnd_chg || g_opnd[1].opnd_chg ||
                  (c_next != c_reg) || (oper_next != oper_reg) ||
                  (sel_next != sel_reg) || (err_next != err_reg);
        lcd_req_next = changed ? 1'b1 : (bus.lcd_ack ? 1'b0 : lcd_req_reg);
    end

    // Control and status registers; refresh requested out of reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg   <= S_EDIT;
            c_reg       <= '0;
            oper_reg    <= PLUS;
            sel_reg     <= 1'b0;
            err_reg     <= 1'b0;
            lcd_req_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            c_reg       <= c_next;
            oper_reg    <= oper_next;
            sel_reg     <= sel_next;
            err_reg     <= err_next;
            lcd_req_reg <= lcd_req_next;
        end
    end

    assign bus.a         = g_opnd[0].opnd_reg;
    assign bus.b         = g_opnd[1].opnd_reg;
    assign bus.c         = c_reg;
    assign bus.operation = oper_reg;
    assign bus.sel       = sel_reg;
    assign bus.alu_start = in_launch;
    assign bus.busy      = !in_edit;
    assign bus.err       = err_reg;
    assign bus.lcd_req   = lcd_req_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios plus random
// pulses, all outputs compared every cycle against a behavioural model.
// Honours CALC_TIMEOUT_EN the same way the design does.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int TO = 8;
`ifdef CALC_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #10 CLK = ~CLK;

    calc_sequencer_if bus ();

    calc_sequencer #(
        .TIMEOUT (TO),
        .A_INIT  (32'h0000_0000),
        .B_INIT  (32'h0000_0000)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model state: mode 0 = editing, 1 = launching, 2 = awaiting ALU.
    logic [31:0] m_a, m_b, m_c;
    logic [1:0]  m_op;
    logic        m_sel, m_err, m_req;
    int          m_mode;
    int          m_waited;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 32'h0; m_b = 32'h0; m_c = 32'h0;
        m_op = 2'b01; m_sel = 1'b0; m_err = 1'b0; m_req = 1'b1;
        m_mode = 0; m_waited = 0;
    endtask

    task automatic model_step();
        logic [31:0] pa = m_a, pb = m_b, pc = m_c;
        logic [1:0]  pop = m_op;
        logic        ps = m_sel, pe = m_err;
        if (m_mode == 0) begin
            if (bus.clr) begin
                if (m_sel) m_b = 32'h0; else m_a = 32'h0;
                m_err = 1'b0;
            end else if (bus.key_valid) begin
                if (m_sel) m_b = (m_b << 4) | 32'(bus.key_code);
                else       m_a = (m_a << 4) | 32'(bus.key_code);
            end else if (bus.sel_tgl) begin
                m_sel = !m_sel;
            end else if (bus.op_next) begin
                m_op = m_op + 2'd1;
            end
            if (bus.go) begin
                m_err  = 1'b0;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            m_mode   = 2;
            m_waited = 0;
        end else begin
            m_waited++;
            if (bus.alu_done) begin
                m_c    = bus.alu_result;
                m_mode = 0;
                txn++;
                $display("txn %0d: result after %0d wait cycles, C=%h", txn, m_waited, m_c);
            end else if (WD_EN && m_waited == TO) begin
                m_err  = 1'b1;
                m_mode = 0;
                txn++;
                $display("txn %0d: watchdog after %0d wait cycles, C=%h", txn, m_waited, m_c);
            end
        end
        if (m_a != pa || m_b != pb || m_c != pc || m_op != pop || m_sel != ps || m_err != pe)
            m_req = 1'b1;
        else if (bus.lcd_ack)
            m_req = 1'b0;
    endtask

    task automatic compare_all();
        check("A", bus.a, m_a);
        check("B", bus.b, m_b);
        check("C", bus.c, m_c);
        check("OPERATION", 32'(bus.operation), 32'(m_op));
        check("SEL", 32'(bus.sel), 32'(m_sel));
        check("ERR", 32'(bus.err), 32'(m_err));
        check("LCD_REQ", 32'(bus.lcd_req), 32'(m_req));
        check("BUSY", 32'(bus.busy), 32'(m_mode != 0));
        check("ALU_START", 32'(bus.alu_start), 32'(m_mode == 1));
    endtask

    task automatic clear_pulses();
        bus.key_valid = 1'b0;
        bus.sel_tgl   = 1'b0;
        bus.op_next   = 1'b0;
        bus.clr       = 1'b0;
        bus.go        = 1'b0;
        bus.alu_done  = 1'b0;
        bus.lcd_ack   = 1'b0;
    endtask

    // One clock: inputs set beforehand are sampled, model advances, outputs checked.
    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
        clear_pulses();
    endtask

    task automatic key(input logic [3:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [3:0]  digits [8];
        logic [31:0] exp_b;
        logic [31:0] hold_a, hold_b;
        logic        hold_sel;
        logic [1:0]  hold_op;
        int          busy_cnt;

        digits = '{4'h3, 4'hF, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        clear_pulses();
        bus.key_code   = 4'h0;
        bus.alu_result = 32'h0;
        model_reset();

        // Reset state
        @(posedge CLK);
        #1;
        check("rst_A", bus.a, 32'h0);
        check("rst_B", bus.b, 32'h0);
        check("rst_C", bus.c, 32'h0);
        check("rst_OP", 32'(bus.operation), 32'h1);
        check("rst_SEL", 32'(bus.sel), 32'h0);
        check("rst_LCD_REQ", 32'(bus.lcd_req), 32'h1);
        compare_all();
        @(negedge CLK);
        RESET = 1'b1;

        // Initial paint acknowledged
        bus.lcd_ack = 1'b1;
        cycle();
        check("ack_drops_req", 32'(bus.lcd_req), 32'h0);

        // Operand entry
        for (int i = 0; i < 8; i++) key(digits[i]);
        bus.sel_tgl = 1'b1;
        cycle();
        key(4'h4);
        check("entry_A", bus.a, 32'h3FC0_0000);
        check("entry_B", bus.b, 32'h0000_0004);
        check("entry_SEL", 32'(bus.sel), 32'h1);

        // Launch with result after 5 WAIT cycles
        bus.go = 1'b1;
        cycle();
        check("launch_start", 32'(bus.alu_start), 32'h1);
        busy_cnt = int'(bus.busy);
        for (int i = 0; i < 6; i++) begin
            cycle();
            busy_cnt += int'(bus.busy);
        end
        bus.alu_done   = 1'b1;
        bus.alu_result = 32'h4000_0000;
        cycle();
        busy_cnt += int'(bus.busy);
        check("busy_cycles", 32'(busy_cnt), 32'd7);
        check("result_C", bus.c, 32'h4000_0000);
        check("result_req", 32'(bus.lcd_req), 32'h1);

`ifdef CALC_TIMEOUT_EN
        // ALU never answers: watchdog ends the wait
        bus.go = 1'b1;
        cycle();
        busy_cnt = int'(bus.busy);
        for (int k = 0; k < 20 && bus.busy; k++) begin
            cycle();
            busy_cnt += int'(bus.busy);
        end
        check("wd_busy_cycles", 32'(busy_cnt), 32'd9);
        check("wd_ERR", 32'(bus.err), 32'h1);
        check("wd_C_kept", bus.c, 32'h4000_0000);
        bus.clr = 1'b1;
        cycle();
        check("clr_ERR", 32'(bus.err), 32'h0);
`else
        // Without a watchdog the wait is unbounded until the ALU answers
        bus.go = 1'b1;
        cycle();
        repeat (30) cycle();
        check("nowd_busy", 32'(bus.busy), 32'h1);
        check("nowd_ERR", 32'(bus.err), 32'h0);
        bus.alu_done   = 1'b1;
        bus.alu_result = 32'h1234_5678;
        cycle();
        check("nowd_C", bus.c, 32'h1234_5678);
`endif

        // Simultaneous edits: only the digit lands
        hold_sel = m_sel;
        hold_op  = m_op;
        exp_b    = m_sel ? ((m_b << 4) | 32'hA) : m_b;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'hA;
        bus.sel_tgl   = 1'b1;
        bus.op_next   = 1'b1;
        cycle();
        check("prio_B", bus.b, exp_b);
        check("prio_SEL", 32'(bus.sel), 32'(hold_sel));
        check("prio_OP", 32'(bus.operation), 32'(hold_op));

        // Inputs during WAIT are ignored
        hold_a = m_a;
        hold_b = m_b;
        bus.go = 1'b1;
        cycle();
        cycle();
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h7;
        bus.go        = 1'b1;
        bus.sel_tgl   = 1'b1;
        cycle();
        check("wait_A", bus.a, hold_a);
        check("wait_B", bus.b, hold_b);
        check("wait_no_start", 32'(bus.alu_start), 32'h0);
        check("wait_SEL", 32'(bus.sel), 32'(hold_sel));
        bus.alu_done   = 1'b1;
        bus.alu_result = 32'hC0FF_EE00;
        cycle();
        check("wait_C", bus.c, 32'hC0FF_EE00);
        bus.lcd_ack   = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h1;
        cycle();
        check("ack_with_edit", 32'(bus.lcd_req), 32'h1);
        bus.lcd_ack = 1'b1;
        cycle();
        check("ack_quiet", 32'(bus.lcd_req), 32'h0);

        // Reset in the middle of a wait, then a stale done
        bus.go = 1'b1;
        cycle();
        cycle();
        cycle();
        RESET = 1'b0;
        #2;
        model_reset();
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_A", bus.a, 32'h0);
        check("midrst_C", bus.c, 32'h0);
        check("midrst_req", 32'(bus.lcd_req), 32'h1);
        compare_all();
        @(negedge CLK);
        RESET = 1'b1;
        bus.alu_done   = 1'b1;
        bus.alu_result = 32'hFFFF_FFFF;
        cycle();
        check("stale_done_C", bus.c, 32'h0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.key_valid  = ($urandom_range(0, 2) == 0);
            bus.key_code   = 4'($urandom_range(0, 15));
            bus.sel_tgl    = ($urandom_range(0, 5) == 0);
            bus.op_next    = ($urandom_range(0, 5) == 0);
            bus.clr        = ($urandom_range(0, 15) == 0);
            bus.go         = ($urandom_range(0, 11) == 0);
            bus.alu_done   = ($urandom_range(0, 5) == 0);
            bus.alu_result = $urandom();
            bus.lcd_ack    = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Controller between user input (keypad, board push-buttons) and the shared float ALU/LCD path of the term-project top level. It holds operands A and B, builds them from hex keypad digits, and selects the operation. On request it launches one ALU transaction with a start/done handshake and captures result C. It then requests a single LCD refresh, which coalesces with any other pending changes.

## Interface
- TIMEOUT, 1024: ALU watchdog limit in cycles, ≥2.
- A_INIT, 32'h0000_0000: reset value of A.
- B_INIT, 32'h0000_0000: reset value of B.
- CLK  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous, active-low reset.
- KEY_VALID  in  1  one-cycle pulse, debounced keypad press.
- KEY_CODE  in  4  hex digit of the press, valid with KEY_VALID.
- SEL_TGL  in  1  pulse: toggle the selected operand (A/B).
- OP_NEXT  in  1  pulse: advance the operation code.
- CLR  in  1  pulse: zero the selected operand, clear ERR.
- GO  in  1  pulse: launch a computation.
- ALU_DONE  in  1  one-cycle pulse, result valid.
- ALU_RESULT  in  32  ALU result, sampled with ALU_DONE.
- LCD_ACK  in  1  one-cycle pulse: LCD has latched A/B/C/OPERATION.
- A, B, C  out  32 each  operands and last result.
- OPERATION  out  2  op code to the ALU/LCD.
- SEL  out  1  0=A, 1=B selected.
- ALU_START  out  1  one-cycle launch pulse.
- BUSY  out  1  high whenever the state is not EDIT.
- ERR  out  1  sticky watchdog error.
- LCD_REQ  out  1  level refresh request.

## Operation
- Reset values: A=A_INIT, B=B_INIT, C=0, OPERATION=PLUS (2'b01), SEL=0, ALU_START=0, ERR=0, LCD_REQ=1 (initial paint), state EDIT.
- States: EDIT → LAUNCH (on GO) → WAIT → EDIT.
- EDIT inputs, priority when several arrive in the same cycle: CLR > KEY_VALID > SEL_TGL > OP_NEXT. Only the highest is acted on; the others are dropped.
  - KEY_VALID: selected operand <= {operand[27:0], KEY_CODE}. The oldest nibble is discarded; there is no digit counter.
  - OP_NEXT: OPERATION <= OPERATION+1, wrapping mod 4.
  - GO: clears ERR and moves to LAUNCH. GO is evaluated independently of the edit inputs, and an edit in the same cycle still applies.
- LAUNCH: lasts one cycle. ALU_START=1 and the watchdog counter is cleared. The next state is WAIT.
- WAIT: ALU_DONE → C <= ALU_RESULT, next state EDIT. On watchdog expiry → ERR=1, C unchanged, next state EDIT.
- Outside EDIT, all edit inputs and GO are ignored, not queued. ALU_DONE is ignored outside WAIT.
- Dirty tracking: any change to A, B, C, OPERATION, SEL or ERR sets dirty. LCD_REQ is the dirty flag.
  - LCD_ACK clears dirty unless a change occurs in the same cycle; in that case LCD_REQ stays high.
  - Multiple changes while LCD_REQ is high coalesce into one request.
- A, B and OPERATION are held stable from LAUNCH until the return to EDIT.

## Timing
- GO sampled at edge n → LAUNCH in cycle n+1 (ALU_START high) → WAIT from cycle n+2.
- ALU_DONE sampled at edge m → C and EDIT visible after edge m; LCD_REQ high after edge m.
- Watchdog counts WAIT cycles. Expiry occurs on the TIMEOUT-th WAIT cycle without ALU_DONE.
- If ALU_DONE and expiry occur in the same cycle, ALU_DONE wins and ERR stays 0.
- Edits take effect at the sampling edge, and LCD_REQ rises the same edge.
- RESET asserted mid-WAIT returns all outputs to reset values immediately. A late ALU_DONE is then ignored, because the state is EDIT.

## Configuration
- CALC_TIMEOUT_EN defined: watchdog present and ERR behaves as above.
- CALC_TIMEOUT_EN undefined: no counter is built, WAIT exits only on ALU_DONE, ERR is tied 0, and the TIMEOUT parameter is unused.

## Structure
- Package calc_pkg holds:
  - state_e: EDIT, LAUNCH, WAIT.
  - op_e: 2-bit; PLUS=2'b01, other codes defined there.
  - localparam WORD_W=32 and NIBBLE_W=4.
- Sub-module calc_watchdog holds the TIMEOUT counter. It has clear and enable inputs and an expired output, and is instantiated only under CALC_TIMEOUT_EN.

## Test plan
- Reset, then LCD_ACK → A=0, B=0, C=0, OPERATION=2'b01, SEL=0, LCD_REQ drops one cycle after the ack.
- Keys 3,F,C,0,0,0,0,0 into A, then SEL_TGL and key 4 → A=32'h3FC0_0000, B=32'h0000_0004, SEL=1.
- Launch with ALU_DONE after 5 WAIT cycles:
  - Stimulus: GO in EDIT, ALU_DONE with ALU_RESULT=32'h4000_0000 after 5 WAIT cycles.
  - Required: ALU_START high exactly cycle n+1, BUSY for 7 cycles, C=32'h4000_0000, LCD_REQ high.
- GO with ALU_DONE never returned (CALC_TIMEOUT_EN, TIMEOUT=8) → ERR=1 after 8 WAIT cycles, C unchanged, EDIT; next CLR clears ERR.
- KEY_VALID, SEL_TGL and OP_NEXT in the same EDIT cycle → only the digit shifts in; SEL and OPERATION unchanged.
- KEY_VALID and GO during WAIT → A/B unchanged, no second ALU_START; an edit coinciding with LCD_ACK keeps LCD_REQ high.
